// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and the bus mode constants
// that the peripheral-side bench also uses.
package spi_pkg;

  // Transaction FSM states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;

  // SPI mode 0: clock idles low, data sampled on the rising edge
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake plus SPI pins of the SPI initiator, with a debug view
// of the transaction FSM state.
//
// Handshake: start is sampled on a clk edge only while busy=0; that edge
// latches txData and raises busy. start while busy=1 is ignored (no queue).
// done pulses for exactly one cycle together with busy falling, and rxData
// is valid from that cycle until the next done. start=1 during the done
// cycle is accepted, so holding start high gives back-to-back transfers.
interface spi_master_if #(parameter int width = 8);
  logic             start;
  logic [width-1:0] txData;
  logic             miso;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic [width-1:0] rxData;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    input  start, txData, miso,
    output sclk, cs_n, mosi, rxData, busy, done, state
  );

  modport slave (
    output start, txData, miso,
    input  sclk, cs_n, mosi, rxData, busy, done, state
  );
endinterface

// File: rtl/spi_clkgen.sv
// Half-period divider for the SPI clock: emits a one-cycle tick every
// clkdiv cycles while enabled, restarting from zero whenever disabled.
module spi_clkgen #(
  parameter int clkdiv = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(clkdiv + 1);
  localparam logic [CW-1:0] LAST = CW'(clkdiv - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Count 0..clkdiv-1 while enabled so the first tick lands clkdiv cycles after enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: shifts one word out on mosi MSB-first while shifting
// miso in, and reports the received word with a one-cycle done pulse.
module spi_master
  import spi_pkg::*;
#(
  parameter int width  = 8,
  parameter int clkdiv = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  spi_master_if.master bus
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LASTBIT = CW'(width);

  logic [1:0]       state;
  logic [CW-1:0]    bitCnt;
  logic [width-1:0] txShift;
  logic [width-1:0] rxShift;
  logic             sclkQ;
  logic             csNQ;
  logic             mosiQ;
  logic             busyQ;
  logic             doneQ;
  logic [width-1:0] rxDataQ;
  logic             phaseEn;
  logic             tick;

  assign phaseEn = (state != IDLE);

  spi_clkgen #(.clkdiv(clkdiv)) u_clkgen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (phaseEn),
    .tick    (tick)
  );

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bitCnt  <= '0;
      txShift <= '0;
      rxShift <= '0;
      sclkQ   <= CPOL;
      csNQ    <= 1'b1;
      mosiQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      rxDataQ <= '0;
    end else begin
      doneQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // MSB goes out immediately; the rest waits in txShift, MSB-aligned
            mosiQ   <= bus.txData[width-1];
            txShift <= {bus.txData[width-2:0], 1'b0};
            rxShift <= '0;
            bitCnt  <= '0;
            csNQ    <= 1'b0;
            busyQ   <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclkQ   <= 1'b1;
            rxShift <= {rxShift[width-2:0], bus.miso};
            bitCnt  <= bitCnt + CW'(1);
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sclkQ <= 1'b0;
            state <= LOW;
            // After the last sample mosi is held through the hold phase
            if (bitCnt != LASTBIT) begin
              mosiQ   <= txShift[width-1];
              txShift <= {txShift[width-2:0], 1'b0};
            end
          end
        end
        LOW: begin
          if (tick) begin
            if (bitCnt == LASTBIT) begin
              csNQ    <= 1'b1;
              busyQ   <= 1'b0;
              doneQ   <= 1'b1;
              rxDataQ <= rxShift;
              state   <= IDLE;
            end else begin
              sclkQ   <= 1'b1;
              rxShift <= {rxShift[width-2:0], bus.miso};
              bitCnt  <= bitCnt + CW'(1);
              state   <= HIGH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk   = sclkQ;
  assign bus.cs_n   = csNQ;
  assign bus.mosi   = mosiQ;
  assign bus.busy   = busyQ;
  assign bus.done   = doneQ;
  assign bus.rxData = rxDataQ;
  assign bus.state  = state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master (width=8, clkdiv=4): a cycle-level model built from
// the transaction timeline checks every output on every cycle, and directed
// scenarios pin the model with hand-computed numbers.
module tb_spi_master;
  import spi_pkg::*;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int TLEN = (2 * W + 1) * D;

  logic clk = 1'b0;
  logic reset_n;
  logic loopback  = 1'b1;
  logic misoConst = 1'b0;
  logic cmpOn     = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_master_if #(.width(W)) bus();

  assign bus.miso = loopback ? bus.mosi : misoConst;

  spi_master #(.width(W), .clkdiv(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction is a fixed timeline of TLEN cycles from its start edge:
  // sclk is high in odd D-long slots, mosi shows bit (W-1 - slot/2), and
  // the cycle at TLEN is the done cycle.
  int             cyc     = 0;
  logic           mActive = 1'b0;
  logic           mDone   = 1'b0;
  logic           mMosi   = 1'b0;
  int             mT      = 0;
  logic [W-1:0]   mWord   = '0;
  logic [W-1:0]   mExpRx  = '0;
  logic [W-1:0]   mRx     = '0;

  always @(posedge clk) begin
    int idx;
    cyc++;
    if (!reset_n) begin
      mActive = 1'b0;
      mDone   = 1'b0;
      mMosi   = 1'b0;
      mRx     = '0;
      mT      = 0;
    end else begin
      mDone = 1'b0;
      if (mActive) begin
        mT++;
        if (mT == TLEN) begin
          mActive = 1'b0;
          mDone   = 1'b1;
          mRx     = mExpRx;
        end
      end else if (bus.start) begin
        mActive = 1'b1;
        mT      = 0;
        mWord   = bus.txData;
        mExpRx  = loopback ? bus.txData : {W{misoConst}};
      end
      if (mActive) begin
        idx = mT / D / 2;
        if (idx > W - 1) idx = W - 1;
        mMosi = mWord[W-1-idx];
      end
    end
  end

  function automatic logic [W+4:0] expOut();
    logic s;
    s = mActive && (mT >= D) && (((mT / D) % 2) == 1);
    return {s, ~mActive, mMosi, mActive, mDone, mRx};
  endfunction

  // ---------------- compare + measurement process ----------------
  int           riseCnt      = 0;
  logic [W-1:0] mosiSeq      = '0;
  int           csLowCnt     = 0;
  int           busyCnt      = 0;
  int           mosiHighBusy = 0;
  int           csHighBetween = 0;
  int           doneCnt      = 0;
  int           doneCyc[4];
  logic [W-1:0] doneRx[4];
  logic         prevSclk     = 1'b0;

  always @(negedge clk) begin
    if (cmpOn)
      check("outputs{sclk,cs_n,mosi,busy,done,rxData}",
            {bus.sclk, bus.cs_n, bus.mosi, bus.busy, bus.done, bus.rxData}, expOut());
    if (bus.sclk && !prevSclk) begin
      riseCnt++;
      mosiSeq = {mosiSeq[W-2:0], bus.mosi};
    end
    prevSclk = bus.sclk;
    if (!bus.cs_n) csLowCnt++;
    if (bus.busy) busyCnt++;
    if (bus.busy && bus.mosi) mosiHighBusy++;
    if (bus.done) begin
      if (doneCnt < 4) begin
        doneCyc[doneCnt] = cyc;
        doneRx[doneCnt]  = bus.rxData;
      end
      doneCnt++;
    end
    if (bus.cs_n && doneCnt == 1) csHighBetween++;
  end

  // ---------------- driver tasks ----------------
  int e0 = 0;

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic clrMeas();
    riseCnt       = 0;
    mosiSeq       = '0;
    csLowCnt      = 0;
    busyCnt       = 0;
    mosiHighBusy  = 0;
    csHighBetween = 0;
    doneCnt       = 0;
  endtask

  task automatic startPulse(input logic [W-1:0] data);
    waitNeg();
    bus.txData = data;
    bus.start  = 1'b1;
    e0 = cyc + 1;
    waitNeg();
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int target, input int bound);
    int n;
    n = 0;
    while (doneCnt < target && n < bound) begin
      waitNeg();
      n++;
    end
    check(name, 32'(doneCnt >= target), 32'd1);
  endtask

  task automatic waitRises(input string name, input int target, input int bound);
    int n;
    n = 0;
    while (riseCnt < target && n < bound) begin
      waitNeg();
      n++;
    end
    check(name, 32'(riseCnt >= target), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start  = 1'b0;
    bus.txData = '0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {bus.sclk, bus.cs_n, bus.mosi, bus.busy, bus.done, bus.rxData},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    check("reset_state", 32'(bus.state), 32'(IDLE));
    reset_n = 1'b1;
    cmpOn   = 1'b1;

    // Loopback A5
    clrMeas();
    loopback = 1'b1;
    startPulse(8'hA5);
    waitDone("A_done_timeout", 1, 200);
    repeat (2) waitNeg();
    check("A_rises", riseCnt, 8);
    check("A_mosi_seq", 32'(mosiSeq), 32'h000000A5);
    check("A_cs_low_cycles", csLowCnt, 68);
    check("A_done_latency", doneCyc[0] - e0, 68);
    check("A_done_count", doneCnt, 1);
    check("A_rxData", 32'(bus.rxData), 32'h000000A5);

    // miso tied high, transmit zeros
    clrMeas();
    loopback  = 1'b0;
    misoConst = 1'b1;
    startPulse(8'h00);
    waitDone("B_done_timeout", 1, 200);
    repeat (2) waitNeg();
    check("B_mosi_high_cycles", mosiHighBusy, 0);
    check("B_busy_cycles", busyCnt, 68);
    check("B_rxData", 32'(bus.rxData), 32'h000000FF);

    // start re-pulsed mid-transfer is ignored
    clrMeas();
    loopback = 1'b1;
    startPulse(8'hA5);
    waitRises("C_rise_timeout", 3, 200);
    bus.txData = 8'h3C;
    bus.start  = 1'b1;
    waitNeg();
    bus.start = 1'b0;
    waitDone("C_done_timeout", 1, 200);
    repeat (100) waitNeg();
    check("C_rises", riseCnt, 8);
    check("C_done_count", doneCnt, 1);
    check("C_rxData", 32'(bus.rxData), 32'h000000A5);

    // back-to-back with start held high
    clrMeas();
    waitNeg();
    bus.txData = 8'h3C;
    bus.start  = 1'b1;
    waitDone("D_done_timeout", 2, 400);
    bus.start = 1'b0;
    repeat (4) waitNeg();
    check("D_done_spacing", doneCyc[1] - doneCyc[0], 69);
    check("D_cs_high_between", csHighBetween, 1);
    check("D_rxData_first", 32'(doneRx[0]), 32'h0000003C);
    check("D_rxData_second", 32'(doneRx[1]), 32'h0000003C);
    check("D_rises", riseCnt, 16);

    // asynchronous reset mid-transaction, then a fresh transfer
    clrMeas();
    startPulse(8'hA5);
    waitRises("E_rise_timeout", 3, 200);
    #2;
    reset_n = 1'b0;
    #1;
    check("E_reset_outputs", {bus.sclk, bus.cs_n, bus.mosi, bus.busy, bus.done, bus.rxData},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (3) waitNeg();
    reset_n = 1'b1;
    clrMeas();
    startPulse(8'h5A);
    waitDone("E_done_timeout", 1, 200);
    repeat (2) waitNeg();
    check("E_rises", riseCnt, 8);
    check("E_rxData", 32'(bus.rxData), 32'h0000005A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator (mode 0, CPOL=0/CPHA=0, MSB first) that drives sclk, cs_n and mosi, and samples miso.
- It is the other end of the peripheral-side shift register used in the SPI memory lab. It serialises one word per transaction and returns the word captured from miso.
- The on-FPGA test harness uses it to exercise the SPI peripheral under a host-style start/done handshake.

Parameters:
- width, 8: bits per transaction. Must be >= 2.
- clkdiv, 4: sclk half-period in clk cycles. Must be >= 1. sclk frequency = clk / (2*clkdiv).

Ports:
- clk  input  1  FPGA clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a transaction. Sampled only when busy=0.
- txData  input  width  word to transmit. Latched on the accepted start edge.
- miso  input  1  serial data from the peripheral.
- sclk  output  1  SPI clock. Idles low.
- cs_n  output  1  chip select, active low. Idles high.
- mosi  output  1  serial data to the peripheral, MSB first.
- rxData  output  width  last received word. Held until the next done.
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle pulse when rxData is valid.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately even mid-transaction):
  - sclk=0, cs_n=1, mosi=0, busy=0, done=0, rxData=0.
  - Internal shift registers and counters clear. State = IDLE.
- All outputs are registered.
- States: IDLE -> SETUP -> HIGH <-> LOW -> IDLE.
- Let D=clkdiv and E0 = the clk edge on which start=1 is sampled in IDLE.
- IDLE:
  - done is deasserted one cycle after it pulses. start=1 latches txData.
  - On E0: cs_n<=0, busy<=1, mosi<=txData[width-1], bit counter<=0, go to SETUP.
- SETUP: sclk stays low for D cycles (data setup before the first rising edge).
- Entering HIGH (sclk 0->1):
  - On that same clk edge, miso is shifted into the LSB of the rx shift register (prior bits move up one).
  - Bit counter increments. sclk stays high for D cycles.
- Entering LOW (sclk 1->0):
  - If fewer than width bits have been sampled, mosi<=next tx bit (MSB-first order) and the FSM returns to HIGH after D cycles.
  - After the width-th bit, mosi is held and the final LOW phase of D cycles serves as hold time.
- Completion, on edge E0+(2*width+1)*D:
  - cs_n<=1, busy<=0, done<=1 for exactly one cycle.
  - rxData<=rx shift register. State = IDLE.
- sclk produces exactly width rising edges per transaction and never glitches. It is low whenever cs_n=1.
- start while busy=1 is ignored; no queuing, and txData changes are ignored.
- start=1 in the done cycle is accepted (busy=0). The next transaction begins on that edge, so cs_n is high for exactly one cycle between transactions.
- start held high continuously produces back-to-back transactions.
- The divider counter wraps 0..D-1. With D=1, sclk toggles every clk cycle.
- rxData changes only on done or reset.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding localparams (IDLE, SETUP, HIGH, LOW).
  - SPI mode constants (CPOL=0, CPHA=0) shared with the peripheral bench.
- One sub-module, spi_clkgen:
  - Counter parameterised by clkdiv.
  - Inputs: clk, reset_n, enable.
  - Outputs: one-cycle tick at each half-period boundary.
  - The FSM in spi_master consumes the tick to decide its transitions.
- Width and bit-counter widths are derived with $clog2(width+1) in spi_master.

Test Plan:
- Reset: hold reset_n=0 mid-run -> same cycle sclk=0, cs_n=1, mosi=0, busy=0, done=0, rxData=0.
- Loopback (miso=mosi), width=8, D=4, txData=8'hA5, pulse start:
  - mosi sequence at sclk rises is 1,0,1,0,0,1,0,1; exactly 8 sclk rises.
  - cs_n low for 68 clk cycles; done=1 one cycle at E0+68; rxData=8'hA5.
- miso tied 1, txData=8'h00 -> mosi constantly 0, rxData=8'hFF, busy high for 68 cycles.
- start re-pulsed with txData=8'h3C after 3 sclk rises -> ignored; 8 rises total, one done, rxData=8'hA5 (loopback of original word).
- Back-to-back: start held high with txData=8'h3C, loopback:
  - two done pulses 69 cycles apart, cs_n high exactly 1 cycle between them.
  - rxData=8'h3C after each.
- Reset mid-transaction after 3 sclk rises -> immediate idle outputs. A later start with 8'h5A in loopback gives rxData=8'h5A with a full 8 rises.
